// File: rtl/ha_bist_pkg.sv
// Shared types and golden model for the half-adder BIST checker.
// The optional first-failure capture in ha_bist_checker is enabled by HA_BIST_FIRST_FAIL_EN.
package ha_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int         NUM_VEC  = 4;
    localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

    // Expected half-adder response for an {a,b} vector, packed as {sum,cout}.
    function automatic logic [1:0] golden(input logic [1:0] ab);
        return {ab[1] ^ ab[0], ab[1] & ab[0]};
    endfunction

endpackage

// File: rtl/ha_bist_settle_timer.sv
// Loadable 4-bit down-counter that times the settle window between driving
// a vector and sampling the half-adder outputs.
module ha_bist_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       expired
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, matching hardware.
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // High during the final cycle of the window, so the owner leaves on the next edge.
    assign expired = (count <= 4'd1);

endmodule

// File: rtl/ha_bist_checker.sv
// Stimulus/response engine that walks all four {a,b} vectors through a half adder
// and scores sum/cout. Define HA_BIST_FIRST_FAIL_EN to add first-failure capture ports.
module ha_bist_checker
    import ha_bist_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int ERR_CNT_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 dut_a,
    output logic                 dut_b,
    input  logic                 dut_sum,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [3:0]           fail_vec
`ifdef HA_BIST_FIRST_FAIL_EN
    ,
    output logic [1:0]           first_fail_idx,
    output logic [1:0]           first_fail_obs,
    output logic                 first_fail_vld
`endif
);

    localparam logic [3:0]           SETTLE_VAL = 4'(SETTLE_CYC);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};

    state_t     state, next_state;
    logic [1:0] vec_idx;
    logic       timer_load;
    logic       timer_en;
    logic       timer_expired;
    logic [1:0] observed;
    logic       mismatch;

    ha_bist_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (SETTLE_VAL),
        .expired  (timer_expired)
    );

    assign observed = {dut_sum, dut_cout};
    assign mismatch = (observed != golden({dut_a, dut_b}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: defaulting every combinational output first keeps partial
        // case coverage from inferring latches.
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = APPLY;
            APPLY:   next_state = (SETTLE_CYC > 0) ? WAIT : CHECK;
            WAIT:    if (timer_expired) next_state = CHECK;
            CHECK:   next_state = (vec_idx == LAST_VEC) ? DONE : APPLY;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state)
            APPLY: begin
                busy       = 1'b1;
                timer_load = 1'b1;
            end
            WAIT: begin
                busy     = 1'b1;
                timer_en = 1'b1;
            end
            CHECK:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Vector drive, scoreboard and results; results persist across IDLE until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dut_a          <= 1'b0;
            dut_b          <= 1'b0;
            vec_idx        <= '0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_vec       <= '0;
`ifdef HA_BIST_FIRST_FAIL_EN
            first_fail_idx <= '0;
            first_fail_obs <= '0;
            first_fail_vld <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_idx        <= '0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        fail_vec       <= '0;
`ifdef HA_BIST_FIRST_FAIL_EN
                        first_fail_idx <= '0;
                        first_fail_obs <= '0;
                        first_fail_vld <= 1'b0;
`endif
                    end
                end
                APPLY: begin
                    dut_a <= vec_idx[1];
                    dut_b <= vec_idx[0];
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_vec[vec_idx] <= 1'b1;
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
`ifdef HA_BIST_FIRST_FAIL_EN
                        if (!first_fail_vld) begin
                            first_fail_idx <= vec_idx;
                            first_fail_obs <= observed;
                            first_fail_vld <= 1'b1;
                        end
`endif
                    end
                    if (vec_idx == LAST_VEC) begin
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                    end else begin
                        vec_idx <= vec_idx + 2'd1;
                    end
                end
                DONE: begin
                    // fail_vec already includes the last vector's verdict here.
                    pass <= (fail_vec == 4'b0000);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ha_bist_checker.sv
// Scoreboard bench: inst 0 uses SETTLE_CYC=2/ERR_CNT_W=3, inst 1 uses SETTLE_CYC=0/ERR_CNT_W=2,
// each driving a behavioural half adder whose fault mode is chosen per run.
module tb_ha_bist_checker;

    typedef struct {
        bit         pass_e;
        logic [3:0] err_e;
        logic [3:0] fv_e;
        int         done_cyc;
        bit         ff_chk;
        logic [1:0] ff_idx;
        logic [1:0] ff_obs;
    } exp_t;

    // start-to-DONE edges: 4 vectors x (settle + 2)
    localparam int LAT0 = 4 * (2 + 2);
    localparam int LAT1 = 4 * (0 + 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic       a [2], b [2], sum [2], cout [2];
    logic       busy [2], done [2], pass [2];
    logic [2:0] err0;
    logic [1:0] err1;
    logic [3:0] fv [2];
    int         mode [2];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
`ifdef HA_BIST_FIRST_FAIL_EN
    logic [1:0] ffi [2], ffo [2];
    logic       ffv [2];
`endif

    exp_t q0 [$];
    exp_t q1 [$];

    ha_bist_checker #(.SETTLE_CYC(2), .ERR_CNT_W(3)) u0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .dut_a(a[0]), .dut_b(b[0]), .dut_sum(sum[0]), .dut_cout(cout[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err0), .fail_vec(fv[0])
`ifdef HA_BIST_FIRST_FAIL_EN
        , .first_fail_idx(ffi[0]), .first_fail_obs(ffo[0]), .first_fail_vld(ffv[0])
`endif
    );

    ha_bist_checker #(.SETTLE_CYC(0), .ERR_CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .dut_a(a[1]), .dut_b(b[1]), .dut_sum(sum[1]), .dut_cout(cout[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err1), .fail_vec(fv[1])
`ifdef HA_BIST_FIRST_FAIL_EN
        , .first_fail_idx(ffi[1]), .first_fail_obs(ffo[1]), .first_fail_vld(ffv[1])
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Half-adder models: 0 good, 1 cout stuck-at-0, 2 sum inverted, 3 sum stuck-at-1.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sum[i]  = a[i] ^ b[i];
            cout[i] = a[i] & b[i];
            case (mode[i])
                1:       cout[i] = 1'b0;
                2:       sum[i]  = ~(a[i] ^ b[i]);
                3:       sum[i]  = 1'b1;
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] err_of(input int i);
        return (i == 0) ? {1'b0, err0} : {2'b00, err1};
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    // Monitor: logs the applied vector sequence, pops an expectation on each done
    // pulse and checks the held results one cycle later.
    exp_t       cur [2];
    bit         pend [2];
    int         nlog [2];
    logic [7:0] seq [2];
    logic [1:0] last_ab [2];

    initial begin
        logic [1:0] ab;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; nlog[i] = 0; seq[i] = '0; last_ab[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    pend[i] = 0; nlog[i] = 0; seq[i] = '0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    ab = {a[i], b[i]};
                    if (busy[i] && (nlog[i] == 0 || ab != last_ab[i])) begin
                        seq[i]     = {seq[i][5:0], ab};
                        nlog[i]    = nlog[i] + 1;
                        last_ab[i] = ab;
                    end
                    if (pend[i]) begin
                        pend[i] = 0;
                        check($sformatf("pass_%0d", i), pass[i], cur[i].pass_e);
                        check($sformatf("err_count_%0d", i), err_of(i), cur[i].err_e);
                        check($sformatf("fail_vec_%0d", i), fv[i], cur[i].fv_e);
`ifdef HA_BIST_FIRST_FAIL_EN
                        if (cur[i].ff_chk) begin
                            check($sformatf("ff_vld_%0d", i), ffv[i], 1'b1);
                            check($sformatf("ff_idx_%0d", i), ffi[i], cur[i].ff_idx);
                            check($sformatf("ff_obs_%0d", i), ffo[i], cur[i].ff_obs);
                        end
`endif
                    end
                    if (done[i]) begin
                        check($sformatf("done_expected_%0d", i), qsize(i) != 0, 1);
                        if (qsize(i) != 0) begin
                            if (i == 0) cur[i] = q0.pop_front();
                            else        cur[i] = q1.pop_front();
                            check($sformatf("done_cycle_%0d", i), cyc, cur[i].done_cyc);
                            check($sformatf("vec_seq_%0d", i), seq[i], 8'b00_01_10_11);
                            check($sformatf("vec_count_%0d", i), nlog[i], 4);
                            check($sformatf("pass_low_in_run_%0d", i), pass[i], 1'b0);
                            pend[i] = 1;
                        end
                        nlog[i] = 0;
                        seq[i]  = '0;
                    end
                end
            end
        end
    end

    task automatic launch(input int i, input int m, input bit p, input logic [3:0] e,
                          input logic [3:0] f, input bit ffc, input logic [1:0] fi,
                          input logic [1:0] fo);
        exp_t x;
        @(negedge clk);
        mode[i]  = m;
        start[i] = 1'b1;
        x.pass_e   = p;
        x.err_e    = e;
        x.fv_e     = f;
        x.done_cyc = cyc + 1 + ((i == 0) ? LAT0 : LAT1);
        x.ff_chk   = ffc;
        x.ff_idx   = fi;
        x.ff_obs   = fo;
        if (i == 0) q0.push_back(x);
        else        q1.push_back(x);
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int n = 0;
        while (qsize(i) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain_in_time_%0d", i), n < 200, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        exp_t x;
        int   c0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            mode[i]  = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_ab_%0d", i), {a[i], b[i]}, 2'b00);
            check($sformatf("rst_busy_done_pass_%0d", i), {busy[i], done[i], pass[i]}, 3'b000);
            check($sformatf("rst_err_%0d", i), err_of(i), 4'd0);
            check($sformatf("rst_fv_%0d", i), fv[i], 4'd0);
        end
        rst = 1'b0;

        // Good adder, cout stuck-at-0, inverted sum (no saturation at width 3).
        launch(0, 0, 1'b1, 4'd0, 4'b0000, 0, 2'b00, 2'b00); drain(0);
        launch(0, 1, 1'b0, 4'd1, 4'b1000, 0, 2'b00, 2'b00); drain(0);
        launch(0, 2, 1'b0, 4'd4, 4'b1111, 0, 2'b00, 2'b00); drain(0);

        // Zero settle: inverted sum saturates width-2 counter; sum stuck-at-1 fails 00 and 11.
        launch(1, 2, 1'b0, 4'd3, 4'b1111, 0, 2'b00, 2'b00); drain(1);
        launch(1, 3, 1'b0, 4'd2, 4'b1001, 1, 2'b00, 2'b10); drain(1);

        // start held high: second run begins from IDLE one cycle after DONE.
        @(negedge clk);
        mode[1]  = 0;
        start[1] = 1'b1;
        c0 = cyc;
        x.pass_e = 1'b1; x.err_e = 4'd0; x.fv_e = 4'b0000;
        x.ff_chk = 0; x.ff_idx = 2'b00; x.ff_obs = 2'b00;
        x.done_cyc = c0 + 1 + LAT1;
        q1.push_back(x);
        x.done_cyc = c0 + 1 + LAT1 + 2 + LAT1;
        q1.push_back(x);
        repeat (15) @(negedge clk);
        start[1] = 1'b0;
        drain(1);

        // start re-pulsed at run cycles 3 and 8 is ignored.
        launch(0, 0, 1'b1, 4'd0, 4'b0000, 0, 2'b00, 2'b00);
        repeat (2) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        drain(0);
        launch(0, 0, 1'b1, 4'd0, 4'b0000, 0, 2'b00, 2'b00); drain(0);

        // Reset during the first WAIT cycle of vector 2 with a failing adder.
        launch(0, 2, 1'b0, 4'd4, 4'b1111, 0, 2'b00, 2'b00);
        repeat (9) @(negedge clk);
        check("pre_rst_err", err0, 3'd2);
        check("pre_rst_fv", fv[0], 4'b0011);
        check("pre_rst_ab", {a[0], b[0]}, 2'b10);
        check("pre_rst_busy", busy[0], 1'b1);
        rst = 1'b1;
        q0.delete();
        #1;
        check("mid_rst_ab", {a[0], b[0]}, 2'b00);
        check("mid_rst_busy", busy[0], 1'b0);
        check("mid_rst_err", err0, 3'd0);
        check("mid_rst_fv", fv[0], 4'b0000);
        check("mid_rst_done", done[0], 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        launch(0, 0, 1'b1, 4'd0, 4'b0000, 0, 2'b00, 2'b00); drain(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/ha_bist_checker.md
Name: ha_bist_checker

Overview:
- Self-checking on-chip stimulus/response engine for the `halfadder` block, implemented as synthesizable sequential RTL.
- Drives all four A/B input combinations into a half-adder instance and samples its sum/cout after a settle window.
- Compares each sample against golden values (sum = a^b, cout = a&b), records failures and reports pass/fail.
- Sits beside a `halfadder` instance in the top-level test harness; this is the driving/checking end of that interface.

Parameters:
- SETTLE_CYC, 2, wait cycles between applying a vector and sampling DUT outputs; legal 0..15.
- ERR_CNT_W, 3, width of the error counter; counter saturates at 2^ERR_CNT_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level sampled in IDLE only; begins one test run.
- dut_a  output  1  A input to the half adder (registered).
- dut_b  output  1  B input to the half adder (registered).
- dut_sum  input  1  sum output from the half adder.
- dut_cout  input  1  carry output from the half adder.
- busy  output  1  high from APPLY of vector 0 through the CHECK of vector 3.
- done  output  1  one-cycle pulse at run end.
- pass  output  1  1 when the last run had zero mismatches; held until the next start.
- err_count  output  ERR_CNT_W  number of failing vectors in the last run (saturating).
- fail_vec  output  4  bit i set when vector i failed; vector i = {a,b} = i.

Behaviour:
- Reset (async, rst=1): state=IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vec_idx=0, timer=0.
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE:
  - Outputs dut_a/dut_b=0.
  - start=1 at an edge: clear err_count and fail_vec, vec_idx=0, go to APPLY.
- APPLY (1 cycle):
  - Register dut_a=vec_idx[1], dut_b=vec_idx[0]; load timer=SETTLE_CYC.
  - Next state is WAIT if SETTLE_CYC>0, else CHECK.
- WAIT:
  - timer decrements each cycle; go to CHECK in the cycle after timer reaches 1.
  - Exactly SETTLE_CYC cycles are spent in WAIT.
- CHECK (1 cycle):
  - Compare dut_sum with dut_a^dut_b and dut_cout with dut_a&dut_b.
  - Any mismatch counts as one error for the vector: fail_vec[vec_idx]=1 and err_count increments, saturating (no wrap).
  - vec_idx<3: vec_idx++, go to APPLY. vec_idx==3: go to DONE.
- DONE (1 cycle):
  - done=1; pass <= (no vector failed in this run, including the CHECK of vector 3); dut_a/dut_b return to 0; go to IDLE.
- Latency: per vector SETTLE_CYC+2 cycles. With start sampled at edge k, done is high in cycle k+1+4*(SETTLE_CYC+2), i.e. 17 cycles after start for the default.
- start while not in IDLE is ignored; start held high re-triggers a new run from IDLE on the following cycle.
- pass, err_count and fail_vec hold their values between runs until the next accepted start clears them; pass also reads 0 during a run.
- Reset mid-run aborts immediately to the reset values; no partial results are kept.
- dut_sum/dut_cout are only observed in CHECK; X/changes at other times are don't-care.

Optional Feature:
- Macro HA_BIST_FIRST_FAIL_EN.
- Defined:
  - Adds outputs first_fail_idx[1:0] and first_fail_obs[1:0] ({sum,cout} observed) plus first_fail_vld.
  - Captured at the first failing CHECK of a run only; cleared on reset and on accepted start.
  - Later failures do not overwrite the capture.
- Undefined: these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Package ha_bist_pkg:
  - State enum (IDLE, APPLY, WAIT, CHECK, DONE).
  - NUM_VEC=4 constant.
  - Golden-model function returning {sum,cout} for {a,b}.
- Sub-module ha_bist_settle_timer: loadable 4-bit down-counter with load, en and expired outputs; instantiated once.
- FSM, scoreboard and counter stay in ha_bist_checker.

Test Plan:
- Correct halfadder attached, SETTLE_CYC=2, start pulse at edge k -> dut_a/dut_b sequence 00,01,10,11; done at cycle k+17; pass=1, err_count=0, fail_vec=4'b0000.
- DUT model with cout stuck-at-0 -> only vector 3 fails: fail_vec=4'b1000, err_count=1, pass=0.
- DUT model with inverted sum, ERR_CNT_W=2 -> all vectors fail: fail_vec=4'b1111, err_count saturates at 3 (not 0), pass=0.
- start re-pulsed at cycles 3 and 8 of a run -> ignored: single done pulse, timing unchanged; then a second run with a correct DUT yields pass=1 and err_count=0.
- rst asserted during WAIT of vector 2 -> same cycle: dut_a=dut_b=0, busy=0, err_count=0, fail_vec=0; no done pulse; a new start then runs normally.
- SETTLE_CYC=0 -> per vector APPLY then CHECK; done at cycle k+9; with HA_BIST_FIRST_FAIL_EN and sum stuck-at-1, first_fail_idx=0 and first_fail_obs=2'b10.
